// File: rtl/obi_arb_pkg.sv
// Shared types for the OBI instruction/data memory arbiter.
// Owner tag and response record registered for the cycle after each grant.
package obi_arb_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_INSTR,
        OWNER_DATA
    } owner_e;

    typedef struct packed {
        owner_e owner;
        logic   err;
    } rsp_t;

    localparam int unsigned WORD_ADDR_LSB = 2;

    // Compares only the bits above the RAM window size.
    function automatic logic addr_in_window(input logic [31:0] addr, input logic [31:0] base,
                                            input int unsigned aw);
        return (addr >> aw) == (base >> aw);
    endfunction

endpackage

// File: rtl/obi_arb_starve_guard.sv
// Saturating count of consecutive denied instruction-request cycles.
// Raises instr_prio once the count reaches STARVE_LIMIT.
module obi_arb_starve_guard #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic instr_req,
    input  logic instr_gnt,
    output logic instr_prio
);

    localparam int unsigned CntWidth = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(STARVE_LIMIT);

    logic [CntWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (instr_gnt) begin
            cnt_d = '0;
        end else if (instr_req && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign instr_prio = (cnt_q == CntMax);

endmodule

// File: rtl/obi_mem_arbiter.sv
// Shares one 1-cycle-latency SRAM between an OBI instruction port and an OBI data port.
// Optional performance counters are built when OBI_ARB_PERF_EN is defined.
module obi_mem_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WIDTH = 22,
    parameter logic [31:0] BASE_ADDR      = 32'h0200_0000,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      instr_req_i,
    output logic                      instr_gnt_o,
    input  logic [31:0]               instr_addr_i,
    output logic                      instr_rvalid_o,
    output logic [31:0]               instr_rdata_o,
    output logic                      instr_err_o,
    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    input  logic [31:0]               data_addr_i,
    input  logic                      data_we_i,
    input  logic [3:0]                data_be_i,
    input  logic [31:0]               data_wdata_i,
    output logic                      data_rvalid_o,
    output logic [31:0]               data_rdata_o,
    output logic                      data_err_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [RAM_ADDR_WIDTH-3:0] mem_addr_o,
    output logic [3:0]                mem_be_o,
    output logic [31:0]               mem_wdata_o,
    input  logic [31:0]               mem_rdata_i
`ifdef OBI_ARB_PERF_EN
    ,
    output logic [31:0]               perf_conflict_o,
    output logic [31:0]               perf_instr_stall_o
`endif
);

    logic        instr_req, data_req, instr_prio, hit, any_gnt;
    logic [31:0] sel_addr;
    rsp_t        rsp_d, rsp_q;
    logic        we_d, we_q;
    logic        rd_ok;

    // No grants while in reset so nothing is left outstanding across it.
    assign instr_req = instr_req_i && !rst_i;
    assign data_req  = data_req_i && !rst_i;

    obi_arb_starve_guard #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_guard (
        .clk       (clk_i),
        .rst       (rst_i),
        .instr_req (instr_req),
        .instr_gnt (instr_gnt_o),
        .instr_prio(instr_prio)
    );

    always_comb begin
        instr_gnt_o = instr_req && (!data_req || instr_prio);
        data_gnt_o  = data_req && !instr_gnt_o;
        any_gnt     = instr_gnt_o || data_gnt_o;
        sel_addr    = data_gnt_o ? data_addr_i : instr_addr_i;
        hit         = addr_in_window(sel_addr, BASE_ADDR, RAM_ADDR_WIDTH);

        mem_req_o   = any_gnt && hit;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_wdata_o = '0;
        if (mem_req_o) begin
            mem_addr_o = sel_addr[RAM_ADDR_WIDTH-1:WORD_ADDR_LSB];
            if (data_gnt_o) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o = 4'hF;
            end
        end

        rsp_d.owner = instr_gnt_o ? OWNER_INSTR : (data_gnt_o ? OWNER_DATA : OWNER_NONE);
        rsp_d.err   = any_gnt && !hit;
        we_d        = data_gnt_o && data_we_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_q <= '{owner: OWNER_NONE, err: 1'b0};
            we_q  <= 1'b0;
        end else begin
            rsp_q <= rsp_d;
            we_q  <= we_d;
        end
    end

    // Gating with rst_i drops a response whose cycle coincides with reset.
    always_comb begin
        instr_rvalid_o = (rsp_q.owner == OWNER_INSTR) && !rst_i;
        data_rvalid_o  = (rsp_q.owner == OWNER_DATA) && !rst_i;
        rd_ok          = !rsp_q.err && !we_q;
        instr_rdata_o  = (instr_rvalid_o && rd_ok) ? mem_rdata_i : 32'h0;
        data_rdata_o   = (data_rvalid_o && rd_ok) ? mem_rdata_i : 32'h0;
        instr_err_o    = instr_rvalid_o && rsp_q.err;
        data_err_o     = data_rvalid_o && rsp_q.err;
    end

`ifdef OBI_ARB_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_conflict_o    <= '0;
            perf_instr_stall_o <= '0;
        end else begin
            if (instr_req_i && data_req_i) begin
                perf_conflict_o <= perf_conflict_o + 32'd1;
            end
            if (instr_req_i && !instr_gnt_o) begin
                perf_instr_stall_o <= perf_instr_stall_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed self-checking bench for obi_mem_arbiter with a behavioural 1-cycle SRAM.
// Performance counter checks are compiled in when OBI_ARB_PERF_EN is defined.
module tb_obi_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_req = 1'b0, data_req = 1'b0, data_we = 1'b0;
    logic [31:0] instr_addr = '0, data_addr = '0, data_wdata = '0;
    logic [3:0]  data_be = '0;
    logic        instr_gnt, instr_rvalid, instr_err;
    logic        data_gnt, data_rvalid, data_err;
    logic [31:0] instr_rdata, data_rdata;
    logic        mem_req, mem_we;
    logic [19:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
`ifdef OBI_ARB_PERF_EN
    logic [31:0] perf_conflict, perf_instr_stall;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] ram [bit [19:0]];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    obi_mem_arbiter dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .instr_req_i   (instr_req),
        .instr_gnt_o   (instr_gnt),
        .instr_addr_i  (instr_addr),
        .instr_rvalid_o(instr_rvalid),
        .instr_rdata_o (instr_rdata),
        .instr_err_o   (instr_err),
        .data_req_i    (data_req),
        .data_gnt_o    (data_gnt),
        .data_addr_i   (data_addr),
        .data_we_i     (data_we),
        .data_be_i     (data_be),
        .data_wdata_i  (data_wdata),
        .data_rvalid_o (data_rvalid),
        .data_rdata_o  (data_rdata),
        .data_err_o    (data_err),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_be_o      (mem_be),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata)
`ifdef OBI_ARB_PERF_EN
        ,
        .perf_conflict_o   (perf_conflict),
        .perf_instr_stall_o(perf_instr_stall)
`endif
    );

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; instr_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        vectors++;
        if ({instr_rvalid, data_rvalid, instr_err, data_err, mem_req, instr_gnt, data_gnt} !== 7'b0
            || instr_rdata !== 32'h0 || data_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got flags=%b irdata=%h drdata=%h, want all 0",
                     {instr_rvalid, data_rvalid, instr_err, data_err, mem_req, instr_gnt, data_gnt},
                     instr_rdata, data_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if ({instr_rvalid, data_rvalid, mem_req, mem_we, mem_be} !== 8'b0 || mem_addr !== 20'h0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got rv=%b%b mem_req=%b we=%b be=%h addr=%h, want 0",
                     instr_rvalid, data_rvalid, mem_req, mem_we, mem_be, mem_addr);
        end
    endtask

    task automatic test_instr_read();
        ram[20'h80000] = 32'hDEAD_BEEF;
        @(negedge clk);
        instr_req = 1'b1; instr_addr = 32'h0220_0000;
        #1;
        vectors++;
        if ({instr_gnt, data_gnt, mem_req, mem_we, mem_be} !== 8'b1010_1111 || mem_addr !== 20'h80000) begin
            miscompares++;
            $display("FAIL instr_req_cycle: got ig/dg/req/we/be=%b%b%b%b%h addr=%h, want 1010F addr=80000",
                     instr_gnt, data_gnt, mem_req, mem_we, mem_be, mem_addr);
        end
        @(posedge clk); #1;
        vectors++;
        if ({instr_rvalid, instr_err, data_rvalid} !== 3'b100 || instr_rdata !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL instr_rsp: got rv/err/drv=%b%b%b rdata=%h, want 100 rdata=deadbeef",
                     instr_rvalid, instr_err, data_rvalid, instr_rdata);
        end
        @(negedge clk);
        instr_req = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (instr_rvalid !== 1'b0 || instr_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL instr_idle_after: got rv=%b rdata=%h, want 0 0", instr_rvalid, instr_rdata);
        end
    endtask

    task automatic test_data_write();
        ram[20'h4] = 32'h0;
        @(negedge clk);
        data_req = 1'b1; data_addr = 32'h0200_0010; data_we = 1'b1; data_be = 4'b0011;
        data_wdata = 32'h1234_5678;
        #1;
        vectors++;
        if ({data_gnt, instr_gnt, mem_req, mem_we, mem_be} !== 8'b1011_0011 || mem_addr !== 20'h4
            || mem_wdata !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL data_write_cycle: got dg/ig/req/we/be=%b%b%b%b%h addr=%h wdata=%h, want 10113 4 12345678",
                     data_gnt, instr_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        vectors++;
        if ({data_rvalid, data_err, instr_rvalid} !== 3'b100 || data_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL data_write_rsp: got rv/err/irv=%b%b%b rdata=%h, want 100 rdata=0",
                     data_rvalid, data_err, instr_rvalid, data_rdata);
        end
        @(negedge clk);
        data_we = 1'b0; data_be = 4'hF;
        #1;
        vectors++;
        if ({mem_req, mem_we} !== 2'b10) begin
            miscompares++;
            $display("FAIL data_read_cycle: got req/we=%b%b, want 10", mem_req, mem_we);
        end
        @(posedge clk); #1;
        vectors++;
        if (data_rvalid !== 1'b1 || data_rdata !== 32'h0000_5678) begin
            miscompares++;
            $display("FAIL data_readback: got rv=%b rdata=%h, want 1 00005678", data_rvalid, data_rdata);
        end
        @(negedge clk);
        data_req = 1'b0;
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        data_req = 1'b1; data_addr = 32'h0000_0100; data_we = 1'b0;
        #1;
        vectors++;
        if ({data_gnt, mem_req, mem_we, mem_be} !== 7'b1000000 || mem_addr !== 20'h0) begin
            miscompares++;
            $display("FAIL oor_req_cycle: got dg/req/we/be=%b%b%b%h addr=%h, want 1000 addr=0",
                     data_gnt, mem_req, mem_we, mem_be, mem_addr);
        end
        @(posedge clk); #1;
        vectors++;
        if ({data_rvalid, data_err, instr_rvalid} !== 3'b110 || data_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL oor_rsp: got rv/err/irv=%b%b%b rdata=%h, want 110 rdata=0",
                     data_rvalid, data_err, instr_rvalid, data_rdata);
        end
        @(negedge clk);
        data_req = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({data_rvalid, data_err} !== 2'b00) begin
            miscompares++;
            $display("FAIL oor_err_clear: got rv/err=%b%b, want 00", data_rvalid, data_err);
        end
    endtask

    task automatic test_starve();
        // Grant order for STARVE_LIMIT=4 with both ports requesting: DDDDIDDDDI.
        logic [9:0] pat = 10'b00001_00001;
        logic       exp_i;
        @(negedge clk);
        instr_req = 1'b1; instr_addr = 32'h0220_0000;
        data_req = 1'b1; data_addr = 32'h0200_0010; data_we = 1'b0; data_be = 4'hF;
        for (int i = 0; i < 10; i++) begin
            exp_i = pat[9-i];
            #1;
            vectors++;
            if ({instr_gnt, data_gnt} !== {exp_i, !exp_i}) begin
                miscompares++;
                $display("FAIL starve_gnt[%0d]: got ig/dg=%b%b, want %b%b",
                         i, instr_gnt, data_gnt, exp_i, !exp_i);
            end
            @(posedge clk); #1;
            vectors++;
            if ({instr_rvalid, data_rvalid} !== {exp_i, !exp_i}
                || instr_rdata !== (exp_i ? 32'hDEAD_BEEF : 32'h0)
                || data_rdata !== (exp_i ? 32'h0 : 32'h0000_5678)) begin
                miscompares++;
                $display("FAIL starve_rsp[%0d]: got irv/drv=%b%b ird=%h drd=%h, want %b%b",
                         i, instr_rvalid, data_rvalid, instr_rdata, data_rdata, exp_i, !exp_i);
            end
            @(negedge clk);
        end
        instr_req = 1'b0; data_req = 1'b0;
`ifdef OBI_ARB_PERF_EN
        vectors++;
        if (perf_conflict !== 32'd10 || perf_instr_stall !== 32'd8) begin
            miscompares++;
            $display("FAIL perf_counters: got conflict=%0d stall=%0d, want 10 8",
                     perf_conflict, perf_instr_stall);
        end
`endif
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        instr_req = 1'b1; instr_addr = 32'h0220_0000;
        data_req = 1'b1; data_addr = 32'h0200_0010; data_we = 1'b0;
        // Four data wins leave the starve counter at its limit.
        repeat (4) @(negedge clk);
        instr_req = 1'b0; data_req = 1'b0; rst = 1'b1;
        #1;
        vectors++;
        if (data_rvalid !== 1'b0 || data_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_drops_rsp: got rv=%b rdata=%h, want 0 0", data_rvalid, data_rdata);
        end
        @(posedge clk); #1;
        vectors++;
        if ({instr_rvalid, data_rvalid, instr_err, data_err, mem_req} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got %b, want 00000",
                     {instr_rvalid, data_rvalid, instr_err, data_err, mem_req});
        end
        @(negedge clk);
        rst = 1'b0; instr_req = 1'b1; data_req = 1'b1;
        #1;
        vectors++;
        if ({instr_gnt, data_gnt} !== 2'b01) begin
            miscompares++;
            $display("FAIL starve_cleared: got ig/dg=%b%b, want 01", instr_gnt, data_gnt);
        end
        @(posedge clk); #1;
        vectors++;
        if ({data_rvalid, instr_rvalid} !== 2'b10) begin
            miscompares++;
            $display("FAIL post_reset_rsp: got drv/irv=%b%b, want 10", data_rvalid, instr_rvalid);
        end
        @(negedge clk);
        instr_req = 1'b0; data_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_instr_read();
        test_data_write();
        test_out_of_range();
        test_reset();
        test_starve();
        test_reset();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/obi_mem_arbiter.md
Name: obi_mem_arbiter

Overview:
- Shares one single-port, 1-cycle-latency SRAM between the core's OBI instruction port and its OBI data port.
- Sits between the core wrapper and the SRAM macro in the SoC top.
- Arbitrates each cycle and tags the winner; routes rdata/rvalid/err back one cycle later.
- Guards instruction fetch against data-side starvation; flags out-of-range accesses with err.

Parameters:
- RAM_ADDR_WIDTH, 22, byte-address width of the RAM window (4 MiB).
- BASE_ADDR, 32'h0200_0000, window base; only bits [31:RAM_ADDR_WIDTH] are compared.
- STARVE_LIMIT, 4, consecutive denied instr-request cycles before instr gets priority; must be ≥1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- instr_req_i  in  1  instr request
- instr_gnt_o  out  1  instr grant, combinational, same cycle
- instr_addr_i  in  32  instr byte address
- instr_rvalid_o  out  1  instr response valid
- instr_rdata_o  out  32  instr read data
- instr_err_o  out  1  instr response error
- data_req_i  in  1  data request
- data_gnt_o  out  1  data grant, combinational
- data_addr_i  in  32  data byte address
- data_we_i  in  1  data write enable
- data_be_i  in  4  data byte enables
- data_wdata_i  in  32  data write data
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  32  data read data
- data_err_o  out  1  data response error
- mem_req_o  out  1  SRAM access strobe
- mem_we_o  out  1  SRAM write
- mem_addr_o  out  RAM_ADDR_WIDTH-2  SRAM word address
- mem_be_o  out  4  SRAM byte enables
- mem_wdata_o  out  32  SRAM write data
- mem_rdata_i  in  32  SRAM read data, valid the cycle after mem_req_o

Behaviour:
- Clocking and reset: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset values:
  - all registered state 0: owner tag = OWNER_NONE, err flag 0, starve counter 0;
  - every rvalid/err output 0; rdata outputs 0.
- Arbitration, evaluated every cycle, at most one grant per cycle:
  - data_req only → data granted;
  - instr_req only → instr granted;
  - both requesting → data wins unless starve_cnt == STARVE_LIMIT, in which case instr wins.
- Starve counter:
  - increments when instr_req_i && !instr_gnt_o;
  - clears on any instr grant;
  - saturates at STARVE_LIMIT.
- In-range granted access (addr[31:RAM_ADDR_WIDTH] == BASE_ADDR[31:RAM_ADDR_WIDTH]):
  - mem_req_o = 1; mem_addr_o = addr[RAM_ADDR_WIDTH-1:2];
  - data winner drives we/be/wdata;
  - instr winner drives mem_we_o = 0 and mem_be_o = 4'hF.
- Out-of-range granted access:
  - mem_req_o = 0; the grant is still given;
  - next cycle the winner's rvalid = 1, err = 1, rdata = 0.
- Response:
  - exactly one cycle after each grant, the granted port sees rvalid = 1;
  - rdata = mem_rdata_i for reads, 0 for writes; err = 0 for in-range accesses;
  - the other port's rvalid stays 0.
- Back-to-back grants are allowed every cycle (full throughput); no other outstanding limit.
- With no request, mem_req_o = 0 and the owner tag becomes OWNER_NONE next cycle.
- mem_* outputs are combinational from the arbitration; when mem_req_o = 0 they are don't-care but driven 0.
- Reset mid-operation: a pending response is discarded (no rvalid after reset); the starve counter clears.

Optional Feature:
- Macro OBI_ARB_PERF_EN.
- When defined, two extra output ports, each a 32-bit wrapping counter, cleared by reset:
  - perf_conflict_o: cycles with both requests high;
  - perf_instr_stall_o: cycles with instr_req_i && !instr_gnt_o.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package obi_arb_pkg:
  - owner_e enum {OWNER_NONE, OWNER_INSTR, OWNER_DATA};
  - packed struct rsp_t {owner, err};
  - localparam WORD_ADDR_LSB = 2.
- One sub-module, obi_arb_starve_guard: the saturating counter plus the instr-priority flag output.

Test Plan:
- Instr-only read of 0x0220_0000 with RAM holding 0xDEADBEEF:
  - instr_gnt_o = 1 same cycle; mem_addr_o = 0x80000;
  - next cycle instr_rvalid_o = 1, rdata = 0xDEADBEEF, err = 0.
- Data write 0x0200_0010, be = 4'b0011, wdata = 0x1234_5678:
  - mem_we_o = 1, mem_be_o = 4'b0011, mem_addr_o = 0x4;
  - next cycle data_rvalid_o = 1, rdata = 0; read-back returns 0x0000_5678 in the low half.
- Both requesting continuously, STARVE_LIMIT = 4:
  - grants follow DDDDI repeating;
  - rvalid pulses appear exactly one cycle after each grant on the matching port.
- Data read of 0x0000_0100 (out of range): data_gnt_o = 1, mem_req_o = 0; next cycle data_rvalid_o = 1, err = 1, rdata = 0.
- rst_i asserted in the cycle after a data grant: no data_rvalid_o follows; all outputs 0 and starve counter 0 after reset.
- With OBI_ARB_PERF_EN, 10 cycles of both requesting: perf_conflict_o = 10; perf_instr_stall_o = 8 (2 instr grants).
